// File: rtl/des_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : des_ctrl_pkg                                                  |
// | Purpose  : Shared definitions for the DES round sequencer: FSM state     |
// |            encodings, default round count, millisecond-to-cycle helper   |
// |            and the per-round key rotate table.                           |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package des_ctrl_pkg;

  // System clock in kHz; c_ms() converts a delay in milliseconds to cycles.
  localparam int c_clk_khz  = 50_000;
  localparam int c_n_rnd_dflt = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FIN   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic int c_ms(input int ms);
    return ms * c_clk_khz;
  endfunction

  // Key rotate amount for round r. Decryption rotates right and skips the
  // rotate in round 0 because the key schedule runs backwards from K16.
  function automatic logic [1:0] ksh_of(input logic mode, input logic [3:0] rnd);
    logic single;
    single = (rnd == 4'd1) || (rnd == 4'd8) || (rnd == 4'd15);
    if (rnd == 4'd0)
      return mode ? 2'd0 : 2'd1;
    else if (single)
      return 2'd1;
    else
      return 2'd2;
  endfunction

endpackage : des_ctrl_pkg
`default_nettype wire

// File: rtl/des_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : des_ctrl_if                                                   |
// | Purpose  : Control bundle between the start logic / DES core and the     |
// |            round sequencer.                                              |
// | Signals  : tr_start, mode, lock   - requests into the sequencer          |
// |            ld, en_rnd, rnd, ksh,  - round datapath controls out of the   |
// |            kdir, fin                sequencer                            |
// |            busy, led_done,        - status out of the sequencer          |
// |            main_done                                                     |
// | Modports : master drives requests, slave (the sequencer) drives controls |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface des_ctrl_if;
  logic       tr_start;
  logic       mode;
  logic       lock;
  logic       ld;
  logic       en_rnd;
  logic [3:0] rnd;
  logic [1:0] ksh;
  logic       kdir;
  logic       fin;
  logic       busy;
  logic       led_done;
  logic       main_done;

  modport master (
    output tr_start, mode, lock,
    input  ld, en_rnd, rnd, ksh, kdir, fin, busy, led_done, main_done
  );

  modport slave (
    input  tr_start, mode, lock,
    output ld, en_rnd, rnd, ksh, kdir, fin, busy, led_done, main_done
  );
endinterface : des_ctrl_if
`default_nettype wire

// File: rtl/des_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : des_ctrl                                                      |
// | Purpose  : Sequencer for the DES round datapath. A start pulse loads     |
// |            key/data, runs N_RND rounds, latches the final permutation,   |
// |            holds the result for HOLD_CMAX cycles and then pulses         |
// |            main_done. Pure control, no data path.                        |
// | Ports    : clk       - system clock                                      |
// |            rst_n     - asynchronous active-low reset                     |
// |            bus       - des_ctrl_if.slave (start/mode/lock in, round      |
// |                        controls and status out)                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module des_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int N_RND     = c_n_rnd_dflt,
  parameter int HOLD_CMAX = c_ms(500)
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  des_ctrl_if.slave   bus
);

  localparam int              c_hold_w    = $clog2(HOLD_CMAX) + 1;
  localparam logic [3:0]      c_rnd_last  = 4'(N_RND - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CMAX - 1);
  localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

  // rnd is only 4 bits wide and the hold compare needs at least one cycle.
  if (N_RND > 16 || N_RND < 1) begin : g_bad_n_rnd
    $error("des_ctrl: N_RND must be in 1..16");
  end
  if (HOLD_CMAX < 1) begin : g_bad_hold_cmax
    $error("des_ctrl: HOLD_CMAX must be >= 1");
  end

  state_t              state_q, state_d;
  logic [3:0]          rnd_cnt_q, rnd_cnt_d;
  logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
  logic                mode_q, mode_d;

  logic                ld_q, ld_d;
  logic                en_rnd_q, en_rnd_d;
  logic [1:0]          ksh_q, ksh_d;
  logic                fin_q, fin_d;
  logic                busy_q, busy_d;
  logic                led_done_q, led_done_d;
  logic                main_done_q, main_done_d;

  logic                w_start_ok;

  // lock masks the start request everywhere; other states never look at it.
  assign w_start_ok = bus.tr_start & ~bus.lock;

  always_comb begin
    state_d    = state_q;
    rnd_cnt_d  = rnd_cnt_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;

    case (state_q)
      S_IDLE: begin
        if (w_start_ok) begin
          state_d = S_LOAD;
          mode_d  = bus.mode;
        end
      end
      S_LOAD: begin
        state_d   = S_ROUND;
        rnd_cnt_d = 4'd0;
      end
      S_ROUND: begin
        // Counter is cleared on exit so rnd reads 0 outside ROUND.
        if (rnd_cnt_q == c_rnd_last) begin
          state_d   = S_FIN;
          rnd_cnt_d = 4'd0;
        end else begin
          rnd_cnt_d = rnd_cnt_q + 4'd1;
        end
      end
      S_FIN: begin
        state_d    = S_HOLD;
        hold_cnt_d = '0;
      end
      S_HOLD: begin
        // A fresh start wins over hold expiry: the board must not power
        // down while a new run is being requested.
        if (w_start_ok) begin
          state_d    = S_LOAD;
          mode_d     = bus.mode;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == c_hold_last) begin
          state_d    = S_DONE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + c_hold_one;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        rnd_cnt_d  = 4'd0;
        hold_cnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered alongside it,
    // so each output flop always matches the current state register.
    ld_d        = (state_d == S_LOAD);
    en_rnd_d    = (state_d == S_ROUND);
    ksh_d       = (state_d == S_ROUND) ? ksh_of(mode_d, rnd_cnt_d) : 2'd0;
    fin_d       = (state_d == S_FIN);
    busy_d      = (state_d == S_LOAD) || (state_d == S_ROUND) || (state_d == S_FIN);
    led_done_d  = (state_d == S_HOLD);
    main_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rnd_cnt_q   <= 4'd0;
      hold_cnt_q  <= '0;
      mode_q      <= 1'b0;
      ld_q        <= 1'b0;
      en_rnd_q    <= 1'b0;
      ksh_q       <= 2'd0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      led_done_q  <= 1'b0;
      main_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_cnt_q   <= rnd_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      mode_q      <= mode_d;
      ld_q        <= ld_d;
      en_rnd_q    <= en_rnd_d;
      ksh_q       <= ksh_d;
      fin_q       <= fin_d;
      busy_q      <= busy_d;
      led_done_q  <= led_done_d;
      main_done_q <= main_done_d;
    end
  end

  assign bus.ld        = ld_q;
  assign bus.en_rnd    = en_rnd_q;
  assign bus.rnd       = rnd_cnt_q;
  assign bus.ksh       = ksh_q;
  assign bus.kdir      = mode_q;
  assign bus.fin       = fin_q;
  assign bus.busy      = busy_q;
  assign bus.led_done  = led_done_q;
  assign bus.main_done = main_done_q;

endmodule : des_ctrl
`default_nettype wire

// File: tb/tb_des_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_des_ctrl                                                   |
// | Purpose  : Scoreboard bench for des_ctrl. Each start pushes the expected |
// |            per-cycle control vectors (with their cycle stamps) into a    |
// |            queue; a monitor pops and compares on every cycle the         |
// |            sequencer is active and checks idle outputs otherwise.        |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_des_ctrl;

  localparam int c_hold = 4;
  localparam int c_run_len = 1 + 16 + 1 + c_hold + 1;

  typedef struct packed {
    logic       ld;
    logic       en_rnd;
    logic [3:0] rnd;
    logic [1:0] ksh;
    logic       kdir;
    logic       fin;
    logic       busy;
    logic       led_done;
    logic       main_done;
  } obs_t;

  typedef struct packed {
    obs_t        o;
    logic [31:0] at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic md_seen = 1'b0;
  exp_t sb[$];

  // Hand-computed key rotate tables.
  logic [1:0] ksh_enc [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  logic [1:0] ksh_dec [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                               2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  des_ctrl_if bus ();

  des_ctrl #(
    .N_RND     (16),
    .HOLD_CMAX (c_hold)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    obs_t o;
    o.ld        = bus.ld;
    o.en_rnd    = bus.en_rnd;
    o.rnd       = bus.rnd;
    o.ksh       = bus.ksh;
    o.kdir      = bus.kdir;
    o.fin       = bus.fin;
    o.busy      = bus.busy;
    o.led_done  = bus.led_done;
    o.main_done = bus.main_done;
    return o;
  endfunction

  // Expected vectors of one run started now (at a falling edge), truncated
  // to the first 'limit' cycles for runs cut short by restart or reset.
  task automatic push_run(input logic m, input int limit);
    exp_t e;
    for (int i = 0; i < c_run_len && i < limit; i++) begin
      e = '0;
      e.at     = 32'(cyc + 1 + i);
      e.o.kdir = m;
      if (i == 0) begin
        e.o.ld   = 1'b1;
        e.o.busy = 1'b1;
      end else if (i <= 16) begin
        e.o.en_rnd = 1'b1;
        e.o.busy   = 1'b1;
        e.o.rnd    = 4'(i - 1);
        e.o.ksh    = m ? ksh_dec[i-1] : ksh_enc[i-1];
      end else if (i == 17) begin
        e.o.fin  = 1'b1;
        e.o.busy = 1'b1;
      end else if (i < 18 + c_hold) begin
        e.o.led_done = 1'b1;
      end else begin
        e.o.main_done = 1'b1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic start_run(input logic m, input int limit);
    push_run(m, limit);
    bus.mode     = m;
    bus.tr_start = 1'b1;
    @(negedge clk);
    bus.tr_start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int i = 0;
    while (sb.size() != 0 && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d expected vectors still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one comparison per falling edge.
  initial begin
    obs_t o;
    exp_t e;
    forever begin
      @(negedge clk);
      o = sample();
      if (o.main_done) md_seen = 1'b1;
      n_vec++;
      if (o.busy || o.led_done || o.main_done || o.ld || o.en_rnd || o.fin) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %h at cyc %0d, required idle", o, cyc);
        end else begin
          e = sb.pop_front();
          if (o !== e.o || 32'(cyc) != e.at) begin
            n_err++;
            $display("FAIL run_vector: got %h at cyc %0d, required %h at cyc %0d",
                     o, cyc, e.o, e.at);
          end
        end
      end else if (o.rnd != 4'd0 || o.ksh != 2'd0) begin
        n_err++;
        $display("FAIL idle_outputs: got rnd=%0d ksh=%0d, required 0/0", o.rnd, o.ksh);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    bus.tr_start = 1'b0;
    bus.mode     = 1'b0;
    bus.lock     = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    o = sample();
    n_vec++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h, required 0", o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: encrypt run
    start_run(1'b0, c_run_len);
    wait_drain(40);
    repeat (2) @(negedge clk);

    // 2: decrypt run, mode flipped during ROUND must not reach kdir
    start_run(1'b1, c_run_len);
    repeat (4) @(negedge clk);
    bus.mode = 1'b0;
    wait_drain(40);
    repeat (2) @(negedge clk);

    // 3a: locked start pulses in IDLE
    bus.lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.tr_start = 1'b1;
      @(negedge clk);
      bus.tr_start = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.ld !== 1'b0) begin
        n_err++;
        $display("FAIL lock_idle: got busy=%b ld=%b, required 0/0", bus.busy, bus.ld);
      end
    end
    bus.lock = 1'b0;
    @(negedge clk);

    // 3b: lock raised at rnd=5 does not abort the run
    start_run(1'b0, c_run_len);
    repeat (6) @(negedge clk);
    bus.lock = 1'b1;
    wait_drain(40);
    bus.lock = 1'b0;
    repeat (2) @(negedge clk);

    // 4a: extra start at rnd=7 is ignored
    start_run(1'b0, c_run_len);
    repeat (8) @(negedge clk);
    bus.tr_start = 1'b1;
    @(negedge clk);
    bus.tr_start = 1'b0;
    wait_drain(40);
    repeat (3) @(negedge clk);

    // 4b: start in the 2nd HOLD cycle restarts with relatched mode
    start_run(1'b0, 18 + 2);
    repeat (19) @(negedge clk);
    start_run(1'b1, c_run_len);
    wait_drain(40);
    repeat (2) @(negedge clk);

    // 5: asynchronous reset at rnd=9
    start_run(1'b1, 11);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    o = sample();
    n_vec++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h before next edge, required 0", o);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    md_seen = 1'b0;
    repeat (30) @(negedge clk);
    n_vec++;
    if (md_seen) begin
      n_err++;
      $display("FAIL reset_no_done: got main_done=1 after aborted run, required 0");
    end

    // 6: back-to-back runs, second started the cycle after main_done
    start_run(1'b0, c_run_len);
    repeat (23) @(negedge clk);
    start_run(1'b0, c_run_len);
    wait_drain(60);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_des_ctrl
`default_nettype wire
